spi_slave: RTL and testbench

SPI responder: the peripheral-side end of the SPI bus driven by the team's SPI master. It oversamples `sck`/`cs`/`mosi` on the system clock, shifts received bits into words on an AXI-stream-style source, and serialises words from an AXI-stream-style sink onto `miso`. It sits between an external SPI master (or the in-house master in loopback benches) and on-chip stream logic.

---
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave -- peripheral-side SPI responder.
//
// Oversamples sck/cs/mosi on clk. Received bits are assembled MSB first into
// words on a valid/ready source. Words from a valid/ready sink are serialised
// onto miso through a one-word holding register.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   sck, cs, mosi         SPI inputs (asynchronous to clk, cs active low)
//   miso, miso_oe         serial data to the master and its output enable
//   tx_tdata/tvalid/tready  transmit word sink
//   rx_tdata/tvalid/tready  receive word source
//   rx_overrun, tx_underrun single-cycle error pulses
//
// Build option: define SPI_SLAVE_ERROR_STATUS_EN to enable the rx_overrun and
// tx_underrun pulses; otherwise both outputs are tied low.
module spi_slave #(
    parameter int                        TRANSFER_WIDTH = 8,
    parameter bit                        CPOL           = 1'b0,
    parameter bit                        CPHA           = 1'b0,
    parameter logic [TRANSFER_WIDTH-1:0] IDLE_WORD      = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sck,
    input  logic                      cs,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    input  logic [TRANSFER_WIDTH-1:0] tx_tdata,
    input  logic                      tx_tvalid,
    output logic                      tx_tready,
    output logic [TRANSFER_WIDTH-1:0] rx_tdata,
    output logic                      rx_tvalid,
    input  logic                      rx_tready,
    output logic                      rx_overrun,
    output logic                      tx_underrun
);

    localparam int                CNT_W    = $clog2(TRANSFER_WIDTH) + 1;
    localparam logic [CNT_W-1:0] WORD_END = CNT_W'(TRANSFER_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state;
    logic                      sck_meta, sck_sync, sck_prev;
    logic                      cs_meta, cs_sync, cs_prev;
    logic                      mosi_meta, mosi_sync;
    logic [CNT_W-1:0]          bit_cnt;
    logic [TRANSFER_WIDTH-1:0] tx_shift, rx_shift, hold_data;
    logic                      hold_full;

    // Two-stage synchronisers plus history registers for edge detection.
    // Idle-level reset values keep reset release from looking like an edge.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_meta  <= CPOL;
            sck_sync  <= CPOL;
            sck_prev  <= CPOL;
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, start, running, boundary, load_word, tx_fire, hold_full_next;

    assign sck_rise    = sck_sync & ~sck_prev;
    assign sck_fall    = ~sck_sync & sck_prev;
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // Only a high-to-low cs transition starts a transfer, so a cs held low
    // across reset is ignored until the master deselects and reselects.
    assign cs_fall   = cs_prev & ~cs_sync;
    assign start     = (state == IDLE) && cs_fall;
    assign running   = (state == ACTIVE) && !cs_sync;
    assign boundary  = running && (bit_cnt == WORD_END);
    assign load_word = start || boundary;
    assign tx_fire   = tx_tvalid && tx_tready;

    // A load always leaves the holding register empty: either its content
    // moves to the shift register or a coincident handshake bypasses it.
    assign hold_full_next = load_word ? 1'b0 : (hold_full | tx_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            tx_tready <= 1'b0;
            rx_tdata  <= '0;
            rx_tvalid <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state <= ACTIVE;
                ACTIVE:  if (cs_sync) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (state == ACTIVE && cs_sync) begin
                // Deselect throws away any partial word.
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (running) begin
                if (boundary) begin
                    bit_cnt <= '0;
                end else if (sample_edge) begin
                    rx_shift <= {rx_shift[TRANSFER_WIDTH-2:0], mosi_sync};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end
                // The first shift edge of a word (count still 0) is skipped:
                // the word load has already placed the MSB on miso.
                if (shift_edge && bit_cnt != '0) begin
                    tx_shift <= {tx_shift[TRANSFER_WIDTH-2:0], 1'b0};
                end
            end

            // Word load takes priority over any shift in the same cycle.
            if (load_word) begin
                if (hold_full) begin
                    tx_shift <= hold_data;
                end else if (tx_fire) begin
                    tx_shift <= tx_tdata;
                end else begin
                    tx_shift <= IDLE_WORD;
                end
            end else if (tx_fire) begin
                hold_data <= tx_tdata;
            end
            hold_full <= hold_full_next;
            tx_tready <= !hold_full_next;

            if (boundary && (!rx_tvalid || rx_tready)) begin
                rx_tdata  <= rx_shift;
                rx_tvalid <= 1'b1;
            end else if (rx_tvalid && rx_tready) begin
                rx_tvalid <= 1'b0;
            end

            miso_oe <= (state == ACTIVE);
            miso    <= (state == ACTIVE) ? tx_shift[TRANSFER_WIDTH-1] : 1'b0;
        end
    end

`ifdef SPI_SLAVE_ERROR_STATUS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overrun  <= boundary && rx_tvalid && !rx_tready;
            tx_underrun <= load_word && !hold_full && !tx_fire;
        end
    end
`else
    assign rx_overrun  = 1'b0;
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed bench for spi_slave.
// Instance 0 runs SPI mode 0, instance 1 runs mode 3; they share sck/mosi
// and have private cs and stream signals.
module tb_spi_slave;

    localparam int HALF = 8;  // sck half period in clk cycles
`ifdef SPI_SLAVE_ERROR_STATUS_EN
    localparam int ERR = 1;
`else
    localparam int ERR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       cs [2];
    logic       miso [2];
    logic       miso_oe [2];
    logic [7:0] tx_tdata [2];
    logic       tx_tvalid [2];
    logic       tx_tready [2];
    logic [7:0] rx_tdata [2];
    logic       rx_tvalid [2];
    logic       rx_tready [2];
    logic       rx_overrun [2];
    logic       tx_underrun [2];

    int n_checks = 0;
    int n_fail = 0;
    int under_cnt [2] = '{0, 0};
    int over_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    spi_slave #(.TRANSFER_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
        .clk(clk), .reset(reset), .sck(sck), .cs(cs[0]), .mosi(mosi),
        .miso(miso[0]), .miso_oe(miso_oe[0]),
        .tx_tdata(tx_tdata[0]), .tx_tvalid(tx_tvalid[0]), .tx_tready(tx_tready[0]),
        .rx_tdata(rx_tdata[0]), .rx_tvalid(rx_tvalid[0]), .rx_tready(rx_tready[0]),
        .rx_overrun(rx_overrun[0]), .tx_underrun(tx_underrun[0])
    );

    spi_slave #(.TRANSFER_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
        .clk(clk), .reset(reset), .sck(sck), .cs(cs[1]), .mosi(mosi),
        .miso(miso[1]), .miso_oe(miso_oe[1]),
        .tx_tdata(tx_tdata[1]), .tx_tvalid(tx_tvalid[1]), .tx_tready(tx_tready[1]),
        .rx_tdata(rx_tdata[1]), .rx_tvalid(rx_tvalid[1]), .rx_tready(rx_tready[1]),
        .rx_overrun(rx_overrun[1]), .tx_underrun(tx_underrun[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_underrun[d] === 1'b1) under_cnt[d]++;
            if (rx_overrun[d] === 1'b1) over_cnt[d]++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_frame(input int d);
        sck = (d == 1);
        wait_clks(HALF);
        cs[d] = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic end_frame(input int d);
        wait_clks(HALF);
        cs[d] = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // Master side of one word (or its first nbits bits), MSB first.
    task automatic xfer(input int d, input logic [7:0] mo, input int nbits,
                        output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (d == 0) begin
                mosi = mo[i];
                wait_clks(HALF);
                sck = 1'b1;
                mi[i] = miso[d];
                wait_clks(HALF);
                sck = 1'b0;
            end else begin
                sck = 1'b0;
                mosi = mo[i];
                wait_clks(HALF);
                sck = 1'b1;
                mi[i] = miso[d];
                wait_clks(HALF);
            end
        end
    endtask

    task automatic push_tx(input int d, input logic [7:0] data);
        int n = 0;
        tx_tdata[d] = data;
        tx_tvalid[d] = 1'b1;
        while (tx_tready[d] !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("tx_handshake_wait", {31'b0, tx_tready[d]}, 32'd1);
        @(negedge clk);
        tx_tvalid[d] = 1'b0;
    endtask

    task automatic pop_rx(input int d, input logic [7:0] exp, input string tag);
        int n = 0;
        while (rx_tvalid[d] !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, rx_tvalid[d]}, 32'd1);
        check({tag, "_data"}, {24'b0, rx_tdata[d]}, {24'b0, exp});
        rx_tready[d] = 1'b1;
        @(negedge clk);
        rx_tready[d] = 1'b0;
        check({tag, "_clear"}, {31'b0, rx_tvalid[d]}, 32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi3 [3];
        int base;

        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b1;
            tx_tdata[d] = '0;
            tx_tvalid[d] = 1'b0;
            rx_tready[d] = 1'b0;
        end

        // Reset state
        wait_clks(3);
        check("rst_miso", {31'b0, miso[0]}, 32'd0);
        check("rst_miso_oe", {31'b0, miso_oe[0]}, 32'd0);
        check("rst_tx_tready", {31'b0, tx_tready[0]}, 32'd0);
        check("rst_rx_tvalid", {31'b0, rx_tvalid[0]}, 32'd0);
        check("rst_rx_tdata", {24'b0, rx_tdata[0]}, 32'd0);
        check("rst_err", {30'b0, rx_overrun[0], tx_underrun[0]}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("tready_after_rst", {31'b0, tx_tready[0]}, 32'd1);

        // Mode 0: tx preloaded 0xA5, master sends 0x3C
        push_tx(0, 8'hA5);
        check("t1_hold_full", {31'b0, tx_tready[0]}, 32'd0);
        base = under_cnt[0];
        begin_frame(0);
        check("t1_miso_oe", {31'b0, miso_oe[0]}, 32'd1);
        check("t1_msb_at_cs", {31'b0, miso[0]}, 32'd1);
        check("t1_no_underrun", under_cnt[0] - base, 32'd0);
        check("t1_hold_emptied", {31'b0, tx_tready[0]}, 32'd1);
        xfer(0, 8'h3C, 8, mi);
        check("t1_miso_word", {24'b0, mi}, 32'hA5);
        check("t1_rx_valid", {31'b0, rx_tvalid[0]}, 32'd1);
        check("t1_rx_data", {24'b0, rx_tdata[0]}, 32'h3C);
        end_frame(0);
        check("t1_oe_idle", {31'b0, miso_oe[0]}, 32'd0);
        check("t1_miso_idle", {31'b0, miso[0]}, 32'd0);
        pop_rx(0, 8'h3C, "t1_pop");

        // Overrun: rx_tready low across two words
        base = over_cnt[0];
        begin_frame(0);
        xfer(0, 8'h12, 8, mi);
        check("t2_no_overrun_first", over_cnt[0] - base, 32'd0);
        xfer(0, 8'h34, 8, mi);
        end_frame(0);
        check("t2_overrun_count", over_cnt[0] - base, ERR);
        check("t2_rx_held", {24'b0, rx_tdata[0]}, 32'h12);
        pop_rx(0, 8'h12, "t2_pop");

        // Underrun: no tx data, master sends 0x00
        base = under_cnt[0];
        begin_frame(0);
        check("t3_underrun_at_cs", under_cnt[0] - base, ERR);
        xfer(0, 8'h00, 8, mi);
        check("t3_idle_word", {24'b0, mi}, 32'hFF);
        end_frame(0);
        pop_rx(0, 8'h00, "t3_pop");

        // Abort after 5 bits, then a fresh 0x9C
        begin_frame(0);
        xfer(0, 8'hF0, 5, mi);
        end_frame(0);
        check("t4_abort_no_word", {31'b0, rx_tvalid[0]}, 32'd0);
        begin_frame(0);
        xfer(0, 8'h9C, 8, mi);
        end_frame(0);
        check("t4_fresh_valid", {31'b0, rx_tvalid[0]}, 32'd1);
        check("t4_fresh_data", {24'b0, rx_tdata[0]}, 32'h9C);

        // Mode 3: three back-to-back words under one cs
        push_tx(1, 8'h11);
        begin_frame(1);
        fork
            begin
                xfer(1, 8'h01, 8, mi3[0]);
                xfer(1, 8'h80, 8, mi3[1]);
                xfer(1, 8'hFF, 8, mi3[2]);
            end
            begin
                push_tx(1, 8'h22);
                push_tx(1, 8'h33);
            end
            begin
                pop_rx(1, 8'h01, "m3_rx0");
                pop_rx(1, 8'h80, "m3_rx1");
                pop_rx(1, 8'hFF, "m3_rx2");
            end
        join
        end_frame(1);
        check("m3_miso0", {24'b0, mi3[0]}, 32'h11);
        check("m3_miso1", {24'b0, mi3[1]}, 32'h22);
        check("m3_miso2", {24'b0, mi3[2]}, 32'h33);

        // Reset at bit 4 with 0x9C still pending on rx
        begin_frame(0);
        xfer(0, 8'hFF, 4, mi);
        check("t5_pending_before", {31'b0, rx_tvalid[0]}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_oe_in_reset", {31'b0, miso_oe[0]}, 32'd0);
        check("t5_valid_in_reset", {31'b0, rx_tvalid[0]}, 32'd0);
        check("t5_data_in_reset", {24'b0, rx_tdata[0]}, 32'd0);
        check("t5_tready_in_reset", {31'b0, tx_tready[0]}, 32'd0);
        wait_clks(3);
        reset = 1'b0;
        xfer(0, 8'h77, 8, mi);
        wait_clks(HALF);
        check("t5_no_word_cs_low", {31'b0, rx_tvalid[0]}, 32'd0);
        check("t5_oe_stays_low", {31'b0, miso_oe[0]}, 32'd0);
        end_frame(0);
        begin_frame(0);
        check("t5_oe_reselect", {31'b0, miso_oe[0]}, 32'd1);
        xfer(0, 8'h5A, 8, mi);
        check("t5_miso_idle_word", {24'b0, mi}, 32'hFF);
        end_frame(0);
        pop_rx(0, 8'h5A, "t5_resume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
